// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and the multi-cycle mul/div unit (MDU). An MDU result is
// parked in a one-entry buffer until it wins the port. The winning write is
// registered once before it reaches the register file, so a grant in cycle N
// shows up on o_rf_* in cycle N+1.
//
// Configuration macro: WBARB_FAIRNESS_EN
//   defined     - a starvation counter forces a buffered MDU result through
//                 after STARVE_MAX consecutive lost arbitrations.
//   not defined - the pipeline has strict priority; the buffer drains only in
//                 cycles where the pipeline does not need the port.
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_wbu_valid / o_wbu_ready      pipeline writeback handshake
//   i_wbu_exres, i_wbu_lsres       execute / load result
//   i_wbu_rdid, i_wbu_rdwen        destination register and write enable
//   i_wbu_ldflag                   selects lsres (1) or exres (0)
//   i_mdu_valid / o_mdu_ready      MDU result handshake into the buffer
//   i_mdu_res, i_mdu_rdid          MDU result and destination
//   o_rf_wen, o_rf_waddr, o_rf_wdata   registered register-file write port
//   o_mdu_pend, o_mdu_pend_rd      buffer occupancy and its rd, for hazards

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

module wb_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wbu_valid,
    output logic                  o_wbu_ready,
    input  logic [`CPU_WIDTH-1:0] i_wbu_exres,
    input  logic [`CPU_WIDTH-1:0] i_wbu_lsres,
    input  logic [`REG_ADDRW-1:0] i_wbu_rdid,
    input  logic                  i_wbu_rdwen,
    input  logic                  i_wbu_ldflag,
    input  logic                  i_mdu_valid,
    output logic                  o_mdu_ready,
    input  logic [`CPU_WIDTH-1:0] i_mdu_res,
    input  logic [`REG_ADDRW-1:0] i_mdu_rdid,
    output logic                  o_rf_wen,
    output logic [`REG_ADDRW-1:0] o_rf_waddr,
    output logic [`CPU_WIDTH-1:0] o_rf_wdata,
    output logic                  o_mdu_pend,
    output logic [`REG_ADDRW-1:0] o_mdu_pend_rd
);

    // The starvation counter must be able to hold STARVE_MAX.
    if ((2 ** CNT_W) <= STARVE_MAX) begin : g_cnt_w_too_small
        $error("wb_port_arbiter: CNT_W too narrow for STARVE_MAX");
    end

    logic                  pipe_req;
    logic [`CPU_WIDTH-1:0] pipe_wdata;
    logic                  force_mdu;
    logic                  buf_grant;
    logic                  pipe_grant;

    logic                  buf_vld_q,   buf_vld_d;
    logic [`REG_ADDRW-1:0] buf_rd_q,    buf_rd_d;
    logic [`CPU_WIDTH-1:0] buf_data_q,  buf_data_d;
    logic                  rf_wen_q,    rf_wen_d;
    logic [`REG_ADDRW-1:0] rf_waddr_q,  rf_waddr_d;
    logic [`CPU_WIDTH-1:0] rf_wdata_q,  rf_wdata_d;
`ifdef WBARB_FAIRNESS_EN
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
`endif

    // Arbitration. Entries that do not write rd never compete for the port,
    // so they are accepted whenever presented.
    always_comb begin
        pipe_req   = i_wbu_valid && i_wbu_rdwen;
        pipe_wdata = i_wbu_ldflag ? i_wbu_lsres : i_wbu_exres;
`ifdef WBARB_FAIRNESS_EN
        force_mdu  = buf_vld_q && (starve_cnt_q == CNT_W'(STARVE_MAX));
`else
        force_mdu  = 1'b0;
`endif
        buf_grant   = buf_vld_q && (!pipe_req || force_mdu);
        pipe_grant  = pipe_req && !force_mdu;
        o_wbu_ready = !i_rst && (!pipe_req || pipe_grant);
        // A draining buffer can take a new result in the same cycle.
        o_mdu_ready = !i_rst && (!buf_vld_q || buf_grant);
    end

    // Next-state for the buffer, the output register and the counter.
    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (i_mdu_valid && o_mdu_ready) begin
            buf_vld_d  = 1'b1;
            buf_rd_d   = i_mdu_rdid;
            buf_data_d = i_mdu_res;
        end else if (buf_grant) begin
            buf_vld_d  = 1'b0;
        end

        // Writes to x0 still consume the grant but never enable the write.
        if (pipe_grant) begin
            rf_wen_d   = (i_wbu_rdid != '0);
            rf_waddr_d = i_wbu_rdid;
            rf_wdata_d = pipe_wdata;
        end else if (buf_grant) begin
            rf_wen_d   = (buf_rd_q != '0);
            rf_waddr_d = buf_rd_q;
            rf_wdata_d = buf_data_q;
        end

`ifdef WBARB_FAIRNESS_EN
        // Counts consecutive lost arbitrations of the buffered result.
        if (!buf_vld_q || buf_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_vld_q    <= 1'b0;
            buf_rd_q     <= '0;
            buf_data_q   <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
`ifdef WBARB_FAIRNESS_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            buf_vld_q    <= buf_vld_d;
            buf_rd_q     <= buf_rd_d;
            buf_data_q   <= buf_data_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
`ifdef WBARB_FAIRNESS_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign o_rf_wen      = rf_wen_q;
    assign o_rf_waddr    = rf_waddr_q;
    assign o_rf_wdata    = rf_wdata_q;
    assign o_mdu_pend    = buf_vld_q;
    assign o_mdu_pend_rd = buf_rd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//
// Directed bench for wb_port_arbiter. A queue-based model of the write port
// predicts every output on each falling clock edge, and the directed
// sequences add hand-computed literal expectations. Expectations that depend
// on WBARB_FAIRNESS_EN follow the same macro as the design.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

module tb_wb_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 3;
`ifdef WBARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  wbuValid;
    logic                  wbuReady;
    logic [`CPU_WIDTH-1:0] wbuExres;
    logic [`CPU_WIDTH-1:0] wbuLsres;
    logic [`REG_ADDRW-1:0] wbuRdid;
    logic                  wbuRdwen;
    logic                  wbuLdflag;
    logic                  mduValid;
    logic                  mduReady;
    logic [`CPU_WIDTH-1:0] mduRes;
    logic [`REG_ADDRW-1:0] mduRdid;
    logic                  rfWen;
    logic [`REG_ADDRW-1:0] rfWaddr;
    logic [`CPU_WIDTH-1:0] rfWdata;
    logic                  mduPend;
    logic [`REG_ADDRW-1:0] mduPendRd;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wbu_valid  (wbuValid),
        .o_wbu_ready  (wbuReady),
        .i_wbu_exres  (wbuExres),
        .i_wbu_lsres  (wbuLsres),
        .i_wbu_rdid   (wbuRdid),
        .i_wbu_rdwen  (wbuRdwen),
        .i_wbu_ldflag (wbuLdflag),
        .i_mdu_valid  (mduValid),
        .o_mdu_ready  (mduReady),
        .i_mdu_res    (mduRes),
        .i_mdu_rdid   (mduRdid),
        .o_rf_wen     (rfWen),
        .o_rf_waddr   (rfWaddr),
        .o_rf_wdata   (rfWdata),
        .o_mdu_pend   (mduPend),
        .o_mdu_pend_rd(mduPendRd)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic wen,
                                 input logic [`REG_ADDRW-1:0] wrd,
                                 input logic ld,
                                 input logic [`CPU_WIDTH-1:0] ex,
                                 input logic [`CPU_WIDTH-1:0] ls,
                                 input logic mv,
                                 input logic [`REG_ADDRW-1:0] mrd,
                                 input logic [`CPU_WIDTH-1:0] mres);
        wbuValid  = wv;
        wbuRdwen  = wen;
        wbuRdid   = wrd;
        wbuLdflag = ld;
        wbuExres  = ex;
        wbuLsres  = ls;
        mduValid  = mv;
        mduRdid   = mrd;
        mduRes    = mres;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic toNegedge();
        @(negedge clk);
        #1;
    endtask

    task automatic toPosedge();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Model: the buffered MDU result lives in a queue; the port goes to the
    // pipeline if it asks and the MDU result is not overdue, otherwise to
    // the buffered result. The write reaches the port one cycle later.
    // ------------------------------------------------------------------
    typedef struct {
        logic [`REG_ADDRW-1:0] rd;
        logic [`CPU_WIDTH-1:0] data;
    } entry_t;

    entry_t                mdlBuf[$];
    int                    mdlWait;
    logic                  mdlWen;
    logic [`REG_ADDRW-1:0] mdlWaddr;
    logic [`CPU_WIDTH-1:0] mdlWdata;
    bit                    modelLive = 1'b0;

    always @(negedge clk) begin
        bit     bufFull;
        bit     pipeAsks;
        bit     overdue;
        bit     pipeWins;
        bit     bufWins;
        bit     mduTaken;
        entry_t e;

        bufFull  = (mdlBuf.size() != 0);
        pipeAsks = wbuValid && wbuRdwen;
        overdue  = FAIR && bufFull && (mdlWait >= STARVE_MAX);
        pipeWins = pipeAsks && !overdue;
        bufWins  = bufFull && !pipeWins;
        mduTaken = mduValid && (!bufFull || bufWins);

        if (modelLive) begin
            checkOutput("mdl_wbu_ready", 32'(wbuReady),
                        32'(!rst && (!pipeAsks || pipeWins)));
            checkOutput("mdl_mdu_ready", 32'(mduReady),
                        32'(!rst && (!bufFull || bufWins)));
            checkOutput("mdl_mdu_pend", 32'(mduPend), 32'(bufFull));
            if (bufFull) begin
                checkOutput("mdl_mdu_pend_rd", 32'(mduPendRd), 32'(mdlBuf[0].rd));
            end
            checkOutput("mdl_rf_wen", 32'(rfWen), 32'(mdlWen));
            checkOutput("mdl_rf_waddr", 32'(rfWaddr), 32'(mdlWaddr));
            checkOutput("mdl_rf_wdata", 32'(rfWdata), 32'(mdlWdata));
        end

        if (rst) begin
            mdlBuf.delete();
            mdlWait   = 0;
            mdlWen    = 1'b0;
            mdlWaddr  = '0;
            mdlWdata  = '0;
            modelLive = 1'b1;
        end else begin
            mdlWen = 1'b0;
            if (pipeWins) begin
                mdlWen   = (wbuRdid != 0);
                mdlWaddr = wbuRdid;
                mdlWdata = wbuLdflag ? wbuLsres : wbuExres;
            end else if (bufWins) begin
                mdlWen   = (mdlBuf[0].rd != 0);
                mdlWaddr = mdlBuf[0].rd;
                mdlWdata = mdlBuf[0].data;
            end
            if (!bufFull || bufWins) begin
                mdlWait = 0;
            end else if (mdlWait < STARVE_MAX) begin
                mdlWait++;
            end
            if (bufWins) begin
                void'(mdlBuf.pop_front());
            end
            if (mduTaken) begin
                e.rd   = mduRdid;
                e.data = mduRes;
                mdlBuf.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequences with literal expectations.
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 32'h1, 32'h2, 1'b0, '0, '0);
        toPosedge();
        toNegedge();
        checkOutput("rst_wbu_ready", 32'(wbuReady), 32'd0);
        checkOutput("rst_mdu_ready", 32'(mduReady), 32'd0);
        toPosedge();
        checkOutput("rst_rf_wen", 32'(rfWen), 32'd0);
        checkOutput("rst_rf_waddr", 32'(rfWaddr), 32'd0);
        checkOutput("rst_rf_wdata", 32'(rfWdata), 32'd0);
        checkOutput("rst_mdu_pend", 32'(mduPend), 32'd0);
        rst = 1'b0;
        applyIdle();
        toPosedge();

        // Pipeline-only load write.
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b1, 32'h5555, 32'h1234, 1'b0, '0, '0);
        toNegedge();
        checkOutput("pipe_ready", 32'(wbuReady), 32'd1);
        toPosedge();
        applyIdle();
        checkOutput("pipe_rf_wen", 32'(rfWen), 32'd1);
        checkOutput("pipe_rf_waddr", 32'(rfWaddr), 32'd5);
        checkOutput("pipe_rf_wdata", 32'(rfWdata), 32'h1234);

        // MDU-only result: buffered one cycle, written the next.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 32'hABCD);
        toNegedge();
        checkOutput("mdu_ready", 32'(mduReady), 32'd1);
        toPosedge();
        applyIdle();
        checkOutput("mdu_pend", 32'(mduPend), 32'd1);
        checkOutput("mdu_pend_rd", 32'(mduPendRd), 32'd7);
        checkOutput("mdu_early_wen", 32'(rfWen), 32'd0);
        toPosedge();
        checkOutput("mdu_rf_wen", 32'(rfWen), 32'd1);
        checkOutput("mdu_rf_waddr", 32'(rfWaddr), 32'd7);
        checkOutput("mdu_rf_wdata", 32'(rfWdata), 32'hABCD);
        checkOutput("mdu_drained", 32'(mduPend), 32'd0);

        // Starvation: buffer rd=11, then hold a pipeline write request.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd11, 32'hBEEF);
        toPosedge();
        applyStimulus(1'b1, 1'b1, 5'd2, 1'b0, 32'h2222, 32'h9999, 1'b0, '0, '0);
        for (int k = 1; k <= 8; k++) begin
            toNegedge();
            checkOutput("starve_wbu_ready", 32'(wbuReady),
                        32'((FAIR && k == STARVE_MAX + 1) ? 1'b0 : 1'b1));
            toPosedge();
            checkOutput("starve_rf_waddr", 32'(rfWaddr),
                        (FAIR && k == STARVE_MAX + 1) ? 32'd11 : 32'd2);
        end
        checkOutput("starve_pend", 32'(mduPend), FAIR ? 32'd0 : 32'd1);
        applyIdle();
        toPosedge();
        checkOutput("starve_idle_wen", 32'(rfWen), FAIR ? 32'd0 : 32'd1);
        checkOutput("starve_idle_waddr", 32'(rfWaddr), FAIR ? 32'd2 : 32'd11);
        checkOutput("starve_idle_pend", 32'(mduPend), 32'd0);

        // Drain-and-fill with a simultaneous no-write pipeline entry.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h33);
        toPosedge();
        applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 32'h44, 32'h45, 1'b1, 5'd9, 32'h99);
        toNegedge();
        checkOutput("fill_wbu_ready", 32'(wbuReady), 32'd1);
        checkOutput("fill_mdu_ready", 32'(mduReady), 32'd1);
        toPosedge();
        applyIdle();
        checkOutput("fill_rf_wen", 32'(rfWen), 32'd1);
        checkOutput("fill_rf_waddr", 32'(rfWaddr), 32'd3);
        checkOutput("fill_rf_wdata", 32'(rfWdata), 32'h33);
        checkOutput("fill_pend_rd", 32'(mduPendRd), 32'd9);
        toPosedge();
        checkOutput("fill2_rf_waddr", 32'(rfWaddr), 32'd9);
        checkOutput("fill2_rf_wdata", 32'(rfWdata), 32'h99);

        // Write to x0 consumes the grant but is not enabled.
        applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 32'hDEAD, 32'h1, 1'b0, '0, '0);
        toPosedge();
        applyIdle();
        checkOutput("x0_rf_wen", 32'(rfWen), 32'd0);
        checkOutput("x0_rf_wdata", 32'(rfWdata), 32'hDEAD);

        // Reset with the buffer full discards the buffered result.
        applyStimulus(1'b1, 1'b1, 5'd1, 1'b0, 32'h11, 32'h0, 1'b1, 5'd6, 32'h66);
        toPosedge();
        checkOutput("rst2_pend_before", 32'(mduPend), 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd1, 1'b0, 32'h11, 32'h0, 1'b0, '0, '0);
        rst = 1'b1;
        toNegedge();
        checkOutput("rst2_wbu_ready", 32'(wbuReady), 32'd0);
        checkOutput("rst2_mdu_ready", 32'(mduReady), 32'd0);
        toPosedge();
        checkOutput("rst2_pend", 32'(mduPend), 32'd0);
        checkOutput("rst2_rf_wen", 32'(rfWen), 32'd0);
        rst = 1'b0;
        applyIdle();
        for (int k = 0; k < 3; k++) begin
            toPosedge();
            checkOutput("rst2_no_stale_wen", 32'(rfWen), 32'd0);
        end

        toNegedge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
